// File: rtl/sdram_port_arbiter_if.sv
// Host-side request/grant signals and SDRAM controller FIFO port signals
// shared by sdram_port_arbiter and its surroundings.
interface sdram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16
);
    logic [1:0]        wr_req;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;
    logic [1:0]        wr_gnt;
    logic              wr_accept;
    logic [1:0]        wr_done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_done;
    logic              wr_fifo_ready;
    logic              rd_fifo_ready;
    logic              ctl_wr;
    logic              ctl_wr_load;
    logic [ADDR_W-1:0] ctl_wr_addr;
    logic [DATA_W-1:0] ctl_wr_data;
    logic              ctl_rd;
    logic              ctl_rd_load;
    logic [ADDR_W-1:0] ctl_rd_addr;
    logic [DATA_W-1:0] ctl_rd_data;

    modport slave (
        input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  rd_req, rd_addr, wr_fifo_ready, rd_fifo_ready, ctl_rd_data,
        output wr_gnt, wr_accept, wr_done, rd_gnt, rd_data, rd_valid, rd_done,
        output ctl_wr, ctl_wr_load, ctl_wr_addr, ctl_wr_data,
        output ctl_rd, ctl_rd_load, ctl_rd_addr
    );

    modport master (
        output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output rd_req, rd_addr, wr_fifo_ready, rd_fifo_ready, ctl_rd_data,
        input  wr_gnt, wr_accept, wr_done, rd_gnt, rd_data, rd_valid, rd_done,
        input  ctl_wr, ctl_wr_load, ctl_wr_addr, ctl_wr_data,
        input  ctl_rd, ctl_rd_load, ctl_rd_addr
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller's host FIFO ports between two burst writers
// and one burst reader, granting one whole burst at a time.
module sdram_port_arbiter #(
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned LOAD_CYCLES = 2,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    sdram_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(BURST_LEN) + 1;
    localparam int unsigned PH_MAX = (LOAD_CYCLES > RD_LAT) ? LOAD_CYCLES : RD_LAT;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {IDLE, WLOAD, WBURST, RLOAD, RWAIT, RBURST, RDRAIN} state_t;

    state_t                        state;
    logic                          ptr;
    logic                          sel;
    logic [1:0]                    wr_gnt;
    logic [1:0]                    wr_done;
    logic [ADDR_W-1:0]             wr_addr_q;
    logic [ADDR_W-1:0]             rd_addr_q;
    logic                          wr_load;
    logic                          rd_load;
    logic                          rd_gnt;
    logic                          rd_strobe;
    logic                          rd_done;
    logic [CNT_W-1:0]              word_cnt;
    logic [PH_W-1:0]               phase_cnt;
    logic [RD_LAT-1:0]             vld_pipe;
    logic [RD_LAT-1:0][DATA_W-1:0] dat_pipe;
    logic                          wr_pick;
    logic                          wr_accept;
    logic                          last_word;
    logic                          load_last;
    logic                          drain_last;

    // Writer 1 wins when it is the only requester or the pointer favours it.
    assign wr_pick    = bus.wr_req[1] & (~bus.wr_req[0] | ptr);
    assign wr_accept  = (state == WBURST) & bus.wr_fifo_ready;
    assign last_word  = (word_cnt == CNT_W'(BURST_LEN - 1));
    assign load_last  = (phase_cnt == PH_W'(LOAD_CYCLES - 1));
    assign drain_last = (phase_cnt == PH_W'(RD_LAT - 1));

    assign bus.wr_gnt      = wr_gnt;
    assign bus.wr_accept   = wr_accept;
    assign bus.wr_done     = wr_done;
    assign bus.rd_gnt      = rd_gnt;
    assign bus.rd_valid    = vld_pipe[RD_LAT-1];
    assign bus.rd_data     = dat_pipe[RD_LAT-1];
    assign bus.rd_done     = rd_done;
    assign bus.ctl_wr      = wr_accept;
    assign bus.ctl_wr_load = wr_load;
    assign bus.ctl_wr_addr = wr_addr_q;
    assign bus.ctl_wr_data = wr_gnt[1] ? bus.wr_data1 : (wr_gnt[0] ? bus.wr_data0 : '0);
    assign bus.ctl_rd      = rd_strobe;
    assign bus.ctl_rd_load = rd_load;
    assign bus.ctl_rd_addr = rd_addr_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            sel       <= 1'b0;
            wr_gnt    <= '0;
            wr_done   <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_load   <= 1'b0;
            rd_load   <= 1'b0;
            rd_gnt    <= 1'b0;
            rd_strobe <= 1'b0;
            rd_done   <= 1'b0;
            word_cnt  <= '0;
            phase_cnt <= '0;
            vld_pipe  <= '0;
            dat_pipe  <= '0;
        end else begin
            wr_done     <= '0;
            rd_done     <= 1'b0;
            vld_pipe[0] <= rd_strobe;
            dat_pipe[0] <= bus.ctl_rd_data;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end

            unique case (state)
                IDLE: begin
                    phase_cnt <= '0;
                    word_cnt  <= '0;
                    if (bus.rd_req) begin
                        rd_addr_q <= bus.rd_addr;
                        rd_load   <= 1'b1;
                        rd_gnt    <= 1'b1;
                        state     <= RLOAD;
                    end else if (|bus.wr_req) begin
                        sel       <= wr_pick;
                        wr_gnt    <= wr_pick ? 2'b10 : 2'b01;
                        wr_addr_q <= wr_pick ? bus.wr_addr1 : bus.wr_addr0;
                        wr_load   <= 1'b1;
                        state     <= WLOAD;
                    end
                end
                WLOAD: begin
                    if (load_last) begin
                        wr_load <= 1'b0;
                        state   <= WBURST;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                WBURST: begin
                    if (wr_accept) begin
                        if (last_word) begin
                            wr_done <= wr_gnt;
                            wr_gnt  <= '0;
                            ptr     <= ~sel;
                            state   <= IDLE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                RLOAD: begin
                    if (load_last) begin
                        rd_load <= 1'b0;
                        state   <= RWAIT;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                RWAIT: begin
                    if (bus.rd_fifo_ready) begin
                        rd_strobe <= 1'b1;
                        word_cnt  <= '0;
                        state     <= RBURST;
                    end
                end
                RBURST: begin
                    if (last_word) begin
                        rd_strobe <= 1'b0;
                        phase_cnt <= '0;
                        state     <= RDRAIN;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                RDRAIN: begin
                    // Last strobe is still in the read pipeline; finish once it lands.
                    if (drain_last) begin
                        rd_done <= 1'b1;
                        rd_gnt  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed bursts push expected
// loads, words and done pulses; a negedge monitor pops and compares.
module tb_sdram_port_arbiter;
    localparam int BL = 16;
    localparam int LC = 2;

    typedef struct {
        bit          is_rd;
        logic [1:0]  gnt;
        logic [17:0] addr;
        bit          b2b;
    } ld_t;

    logic Clk = 1'b0;
    logic Reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] tag0 = 8'h00, tag1 = 8'h00, rtag = 8'h00;
    logic [3:0] idx0, idx1, rptr;

    ld_t         q_ld[$];
    logic [16:0] q_wr[$];
    logic [15:0] q_rd[$];
    logic [2:0]  q_done[$];

    bit   ld_prev = 0, rd_prev = 0, rd_stall = 0;
    int   ld_len = 0, rd_run = 0, burst_words = 0;
    int   last_evt_cyc = 0, last_done_cyc = -10, exp_first_rd = -1;
    ld_t  e;
    logic [16:0] w;
    logic [15:0] d;
    logic [2:0]  dn;

    sdram_port_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus ();

    sdram_port_arbiter #(
        .BURST_LEN(16), .ADDR_W(18), .DATA_W(16), .LOAD_CYCLES(2), .RD_LAT(1)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Host writers and controller read FIFO: word index advances on each transfer.
    assign bus.wr_data0    = {4'hA, tag0, idx0};
    assign bus.wr_data1    = {4'hB, tag1, idx1};
    assign bus.ctl_rd_data = {4'hC, rtag, rptr};

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx0 <= 4'd0;
            idx1 <= 4'd0;
            rptr <= 4'd0;
        end else begin
            if (bus.wr_accept && bus.wr_gnt[0]) idx0 <= idx0 + 4'd1;
            if (bus.wr_accept && bus.wr_gnt[1]) idx1 <= idx1 + 4'd1;
            if (bus.ctl_rd) rptr <= rptr + 4'd1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic push_wr(input bit s, input logic [17:0] a, input logic [7:0] tag, input bit b2b);
        q_ld.push_back('{1'b0, s ? 2'b10 : 2'b01, a, b2b});
        for (int k = 0; k < BL; k++) q_wr.push_back({s, s ? 4'hB : 4'hA, tag, 4'(k)});
        q_done.push_back({1'b0, s ? 2'b10 : 2'b01});
    endtask

    task automatic push_rd(input logic [17:0] a, input logic [7:0] tag, input bit b2b);
        q_ld.push_back('{1'b1, 2'b00, a, b2b});
        for (int k = 0; k < BL; k++) q_rd.push_back({4'hC, tag, 4'(k)});
        q_done.push_back(3'b100);
    endtask

    task automatic wait_gnt(input logic [1:0] g, input bit rd);
        int n = 0;
        while (!(rd ? bus.rd_gnt : (bus.wr_gnt == g)) && n < 400) begin
            tick(1);
            n++;
        end
        if (n >= 400) unexp("gnt_timeout");
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (!bus.wr_done[i] && n < 400) begin
            tick(1);
            n++;
        end
        if (n >= 400) unexp("done_timeout");
        bus.wr_req[i] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q_ld.size() + q_wr.size() + q_rd.size() + q_done.size()) != 0 && n < 600) begin
            tick(1);
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d loads %0d wr %0d rd %0d done still expected",
                     q_ld.size(), q_wr.size(), q_rd.size(), q_done.size());
        end
        tick(3);
    endtask

    task automatic do_reset();
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b0;
        Reset_n = 1'b0;
        #1;
        chk("reset_outputs", 128'({bus.wr_gnt, bus.wr_accept, bus.wr_done, bus.rd_gnt, bus.rd_data,
                                   bus.rd_valid, bus.rd_done, bus.ctl_wr, bus.ctl_wr_load,
                                   bus.ctl_wr_addr, bus.ctl_wr_data, bus.ctl_rd, bus.ctl_rd_load,
                                   bus.ctl_rd_addr}), 128'd0);
        q_ld.delete();
        q_wr.delete();
        q_rd.delete();
        q_done.delete();
        rd_stall = 0;
        tick(2);
        Reset_n = 1'b1;
        tick(1);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                ld_prev = 0; ld_len = 0; rd_prev = 0; rd_run = 0; burst_words = 0;
            end else begin
                if (bus.ctl_wr_load || bus.ctl_rd_load) begin
                    if (!ld_prev) begin
                        if (q_ld.size() == 0) unexp("load");
                        else begin
                            e = q_ld.pop_front();
                            chk("load", 128'({bus.ctl_wr_load, bus.ctl_rd_load, bus.rd_gnt, bus.wr_gnt,
                                              e.is_rd ? bus.ctl_rd_addr : bus.ctl_wr_addr}),
                                128'({!e.is_rd, e.is_rd, e.is_rd, e.gnt, e.addr}));
                            if (e.b2b) chk("idle_gap", 128'(cyc), 128'(last_done_cyc + 1));
                        end
                        burst_words = 0;
                        ld_len = 0;
                    end
                    ld_len++;
                end else if (ld_prev) begin
                    chk("load_len", 128'(ld_len), 128'(LC));
                end
                ld_prev = bus.ctl_wr_load || bus.ctl_rd_load;

                if (bus.ctl_wr) begin
                    if (q_wr.size() == 0) unexp("wr_word");
                    else begin
                        w = q_wr.pop_front();
                        chk("wr_word", 128'({bus.wr_gnt, bus.wr_accept, bus.wr_fifo_ready, bus.ctl_wr_data}),
                            128'({w[16] ? 2'b10 : 2'b01, 1'b1, 1'b1, w[15:0]}));
                    end
                    burst_words++;
                    last_evt_cyc = cyc;
                end

                if (bus.ctl_rd) begin
                    if (!rd_prev && rd_stall) begin
                        chk("rd_start", 128'(cyc), 128'(exp_first_rd));
                        rd_stall = 0;
                    end
                    rd_run++;
                end else if (rd_prev) begin
                    chk("rd_run", 128'(rd_run), 128'(BL));
                    rd_run = 0;
                end
                rd_prev = bus.ctl_rd;

                if (bus.rd_valid) begin
                    if (q_rd.size() == 0) unexp("rd_word");
                    else begin
                        d = q_rd.pop_front();
                        chk("rd_word", 128'({bus.rd_gnt, bus.rd_data}), 128'({1'b1, d}));
                    end
                    burst_words++;
                    last_evt_cyc = cyc;
                end

                if (bus.wr_done != 2'b00 || bus.rd_done) begin
                    if (q_done.size() == 0) unexp("done");
                    else begin
                        dn = q_done.pop_front();
                        chk("done", 128'({bus.rd_done, bus.wr_done, bus.wr_gnt, bus.rd_gnt}),
                            128'({dn, 2'b00, 1'b0}));
                        chk("done_timing", 128'({burst_words, cyc - last_evt_cyc}), 128'({BL, 32'd1}));
                    end
                    last_done_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    // Stimulus
    initial begin
        Reset_n           = 1'b1;
        bus.wr_req        = 2'b00;
        bus.wr_addr0      = '0;
        bus.wr_addr1      = '0;
        bus.rd_req        = 1'b0;
        bus.rd_addr       = '0;
        bus.wr_fifo_ready = 1'b1;
        bus.rd_fifo_ready = 1'b1;
        #1;
        do_reset();

        // Single writer-0 burst
        tag0 = 8'h11;
        bus.wr_addr0 = 18'h00100;
        push_wr(1'b0, 18'h00100, 8'h11, 1'b0);
        bus.wr_req = 2'b01;
        wait_done(0);
        wait_drain();

        // Both writers requesting: 01, 10, 01 back to back
        do_reset();
        tag0 = 8'h21; tag1 = 8'h22;
        bus.wr_addr0 = 18'h01000;
        bus.wr_addr1 = 18'h3FFF0;
        push_wr(1'b0, 18'h01000, 8'h21, 1'b0);
        push_wr(1'b1, 18'h3FFF0, 8'h22, 1'b1);
        push_wr(1'b0, 18'h01000, 8'h21, 1'b1);
        bus.wr_req = 2'b11;
        wait_done(1);
        wait_done(0);
        wait_drain();

        // Read and writer 0 in the same cycle: read first
        tag0 = 8'h31; rtag = 8'h33;
        bus.rd_addr = 18'h0ABCD;
        push_rd(18'h0ABCD, 8'h33, 1'b0);
        push_wr(1'b0, 18'h01000, 8'h31, 1'b1);
        bus.rd_req = 1'b1;
        bus.wr_req = 2'b01;
        wait_gnt(2'b00, 1'b1);
        bus.rd_req = 1'b0;
        wait_done(0);
        wait_drain();

        // Write FIFO ready toggling every cycle
        tag0 = 8'h41;
        bus.wr_addr0 = 18'h00000;
        push_wr(1'b0, 18'h00000, 8'h41, 1'b0);
        bus.wr_req = 2'b01;
        for (int n = 0; n < 400 && !bus.wr_done[0]; n++) begin
            tick(1);
            bus.wr_fifo_ready = ~bus.wr_fifo_ready;
        end
        if (!bus.wr_done[0]) unexp("toggle_timeout");
        bus.wr_req = 2'b00;
        bus.wr_fifo_ready = 1'b1;
        wait_drain();

        // Read FIFO not ready for 20 cycles after the load
        rtag = 8'h51;
        bus.rd_addr = 18'h12345;
        bus.rd_fifo_ready = 1'b0;
        exp_first_rd = -1;
        rd_stall = 1;
        push_rd(18'h12345, 8'h51, 1'b0);
        bus.rd_req = 1'b1;
        wait_gnt(2'b00, 1'b1);
        bus.rd_req = 1'b0;
        tick(LC + 20);
        bus.rd_fifo_ready = 1'b1;
        exp_first_rd = cyc + 1;
        wait_drain();

        // Reset at word 7 of a writer-1 burst; pointer returns to writer 0
        tag1 = 8'h61;
        bus.wr_addr1 = 18'h20000;
        push_wr(1'b1, 18'h20000, 8'h61, 1'b0);
        bus.wr_req = 2'b10;
        for (int n = 0; n < 400 && idx1 != 4'd7; n++) tick(1);
        chk("abort_point", 128'(idx1), 128'(7));
        do_reset();
        tag0 = 8'h62;
        bus.wr_addr0 = 18'h00200;
        push_wr(1'b0, 18'h00200, 8'h62, 1'b0);
        push_wr(1'b1, 18'h20000, 8'h61, 1'b1);
        bus.wr_req = 2'b11;
        wait_done(0);
        wait_done(1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Sequences and shares the host-side FIFO ports of the SDRAM controller between two burst writers (game-state writer, frame clear engine) and one burst reader (display line prefetch).
- Grants one requester at a time for a whole burst.
- Drives address loads and word strobes; returns read data with a valid flag.
- Sits between the game/display logic and the SDRAM controller in the top level, on the 100 MHz PLL clock domain.

Parameters:
BURST_LEN, 16, words per burst (matches controller WR_LENGTH/RD_LENGTH)
ADDR_W, 18, SDRAM word address width
DATA_W, 16, data word width
LOAD_CYCLES, 2, cycles the load strobe is held
RD_LAT, 1, cycles from ctl_rd to valid ctl_rd_data

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
wr_req  in  2  burst write request, bit i = writer i
wr_addr0, wr_addr1  in  ADDR_W each  start address of writer 0 / writer 1
wr_data0, wr_data1  in  DATA_W each  current write word of writer 0 / writer 1
wr_gnt  out  2  one-hot grant, held for the whole burst
wr_accept  out  1  granted writer's word consumed this cycle
wr_done  out  2  one-cycle burst-complete pulse, bit i = writer i
rd_req  in  1  burst read request
rd_addr  in  ADDR_W  read start address
rd_gnt  out  1  read burst in progress
rd_data  out  DATA_W  read word
rd_valid  out  1  rd_data valid
rd_done  out  1  one-cycle read-complete pulse
wr_fifo_ready  in  1  controller write FIFO can take a word
rd_fifo_ready  in  1  controller read FIFO holds at least BURST_LEN words
ctl_wr, ctl_wr_load  out  1 each  controller WR and WR_LOAD
ctl_wr_addr  out  ADDR_W  controller WR_ADDR
ctl_wr_data  out  DATA_W  controller WR_DATA
ctl_rd, ctl_rd_load  out  1 each  controller RD and RD_LOAD
ctl_rd_addr  out  ADDR_W  controller RD_ADDR
ctl_rd_data  in  DATA_W  controller RD_DATA

Behaviour:
- Reset (async, Reset_n=0):
  - state IDLE, round-robin pointer = writer 0.
  - All outputs 0, including latched addresses.
  - Any in-flight burst is abandoned; no rd_valid or done pulse is emitted after reset.
- States: IDLE, WLOAD, WBURST, RLOAD, RWAIT, RBURST, RDRAIN.
- IDLE arbitration, decided each cycle:
  - rd_req=1 has priority: latch rd_addr, go to RLOAD.
  - Otherwise, if any wr_req: pick the requester the pointer favours; if only one requests, pick it. Latch its address, set wr_gnt one-hot, go to WLOAD.
- Write path:
  - WLOAD: ctl_wr_addr = latched address; ctl_wr_load=1 for exactly LOAD_CYCLES cycles, then go to WBURST.
  - WBURST: ctl_wr = wr_accept = wr_fifo_ready (combinational). ctl_wr_data = granted writer's data (combinational mux).
  - The 5-bit word counter increments on each accepted word. wr_fifo_ready=0 stalls with no strobe.
  - On the BURST_LEN-th accepted word: next state IDLE, wr_done[i] pulses in the following cycle, wr_gnt clears, pointer moves to the other writer.
- Read path:
  - RLOAD: ctl_rd_addr latched; ctl_rd_load=1 for LOAD_CYCLES cycles, then go to RWAIT.
  - RWAIT: wait for rd_fifo_ready=1, then go to RBURST.
  - RBURST: ctl_rd=1 for exactly BURST_LEN consecutive cycles.
  - rd_valid/rd_data = ctl_rd/ctl_rd_data delayed RD_LAT cycles through a shift register.
  - RDRAIN: hold RD_LAT cycles. rd_done pulses in the cycle after the last rd_valid, then go to IDLE.
  - rd_gnt=1 from RLOAD through RDRAIN.
- Once granted, a burst always completes; requester deassertion mid-burst is ignored.
- Requests arriving mid-burst wait in IDLE for the next decision. Back-to-back bursts have exactly one IDLE cycle between them.
- Addresses pass through unmodified (the controller auto-increments). No alignment check is made.
- Writers must hold wr_req until wr_done. Continuous rd_req can starve writers; the display duty cycle bounds this.

Test Plan:
- Reset, wr_req=01, addr0=0x00100, wr_fifo_ready=1 -> wr_gnt=01, ctl_wr_load high 2 cycles with addr 0x00100, 16 consecutive ctl_wr with writer-0 data, wr_done=01 one cycle later.
- wr_req=11 held continuously -> grants alternate 01,10,01; each burst is 16 words; one IDLE cycle between bursts.
- rd_req and wr_req=01 asserted in the same IDLE cycle -> read burst first (rd_gnt, 16 rd_valid words matching ctl_rd_data), then writer 0.
- wr_fifo_ready toggled 1,0,1,0 during WBURST -> ctl_wr only on ready cycles; exactly 16 accepts; wr_done after the 16th.
- rd_fifo_ready held 0 for 20 cycles after RLOAD -> no ctl_rd; burst starts the cycle after ready rises; rd_done after the 16th valid.
- Reset_n low at word 7 of a write burst -> outputs 0 immediately; no wr_done; after release, the pointer favours writer 0 and a new burst starts with a fresh load.
